// File: rtl/idct_pkg.sv
// Shared IDCT definitions: transpose FSM states, block geometry and
// the column-major address helper.
package idct_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int BLK_SIZE = 64;
  localparam int DIM      = 8;

  // Swapping the row and column fields of a row-major index walks the block column by column.
  function automatic logic [5:0] col_major_addr(input logic [5:0] idx);
    return {idx[2:0], idx[5:3]};
  endfunction

endpackage

// File: rtl/idct_transpose_ctrl.sv
// Transpose controller between the IDCT row and column passes: fills a
// 64-entry memory in row-major order, then drains it in column-major order.
module idct_transpose_ctrl
  import idct_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             mem_w_en,
  output logic [5:0]       mem_w_addr,
  output logic [WIDTH-1:0] mem_d_in,
  output logic             mem_r_en,
  output logic [5:0]       mem_r_addr,
  input  logic [WIDTH-1:0] mem_d_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             blk_done
);

  state_t     state, state_next;
  logic [5:0] wr_cnt, wr_cnt_next;
  logic [6:0] rd_cnt, rd_cnt_next;
  logic       out_valid, out_valid_next;
  logic       out_last, out_last_next;

  logic wr_fire;
  logic issue;
  logic out_fire;
  logic done;

  // Handshake and memory strobes are gated by rst_n so nothing moves while reset is held.
  assign s_ready  = rst_n && (state == FILL);
  assign wr_fire  = s_valid && s_ready;
  assign issue    = rst_n && (state == DRAIN) && (rd_cnt < 7'(BLK_SIZE))
                    && (!out_valid || m_ready);
  assign out_fire = out_valid && m_ready;
  assign done     = out_fire && out_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_next;
      wr_cnt    <= wr_cnt_next;
      rd_cnt    <= rd_cnt_next;
      out_valid <= out_valid_next;
      out_last  <= out_last_next;
    end
  end

  always_comb begin
    state_next     = state;
    wr_cnt_next    = wr_cnt;
    rd_cnt_next    = rd_cnt;
    out_valid_next = out_valid;
    out_last_next  = out_last;

    case (state)
      FILL:    if (wr_fire && (wr_cnt == 6'(BLK_SIZE - 1))) state_next = DRAIN;
      DRAIN:   if (done) state_next = FILL;
      default: state_next = FILL;
    endcase

    // The 6-bit counter wraps to 0 on the 64th beat by itself.
    if (wr_fire) wr_cnt_next = wr_cnt + 6'd1;

    if (done)       rd_cnt_next = '0;
    else if (issue) rd_cnt_next = rd_cnt + 7'd1;

    // Read data lands one cycle after an issue, so valid/last track the issue with a cycle of delay.
    if (issue) begin
      out_valid_next = 1'b1;
      out_last_next  = (rd_cnt[5:0] == 6'(BLK_SIZE - 1));
    end else if (m_ready) begin
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
    end
  end

  assign mem_w_en   = wr_fire;
  assign mem_w_addr = wr_cnt;
  assign mem_d_in   = s_data;
  assign mem_r_en   = issue;
  assign mem_r_addr = col_major_addr(rd_cnt[5:0]);
  assign m_valid    = out_valid;
  assign m_data     = mem_d_out;
  assign m_last     = out_valid && out_last;
  assign blk_done   = done;

endmodule

// File: tb/tb_idct_transpose_ctrl.sv
// Directed bench for idct_transpose_ctrl with a behavioural 64-entry
// registered-read memory and an order-checking transpose model.
module tb_idct_transpose_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             mem_w_en;
  logic [5:0]       mem_w_addr;
  logic [WIDTH-1:0] mem_d_in;
  logic             mem_r_en;
  logic [5:0]       mem_r_addr;
  logic [WIDTH-1:0] mem_d_out;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             blk_done;

  always #5 clk = ~clk;

  idct_transpose_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .mem_w_en  (mem_w_en),
    .mem_w_addr(mem_w_addr),
    .mem_d_in  (mem_d_in),
    .mem_r_en  (mem_r_en),
    .mem_r_addr(mem_r_addr),
    .mem_d_out (mem_d_out),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .blk_done  (blk_done)
  );

  // Block memory owned by the parent: registered read, output held when not reading.
  logic [WIDTH-1:0] mem [64];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_d_in;
    if (mem_r_en) mem_d_out <= mem[mem_r_addr];
  end

  int vecs = 0;
  int miscompares = 0;

  int               cyc = 0;
  int               base = 0;
  int               wr_idx = 0;
  int               out_idx = 0;
  int               blocks_done = 0;
  int               w64_cyc = 0;
  bit               first_seen = 1'b0;
  bit               chk_ready = 1'b0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [WIDTH-1:0] blk_vals [64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    wr_idx     = 0;
    out_idx    = 0;
    first_seen = 1'b0;
    chk_ready  = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = '0;
    m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_last", m_last, 0);
      check_eq("rst_blk_done", blk_done, 0);
      check_eq("rst_w_en", mem_w_en, 0);
      check_eq("rst_r_en", mem_r_en, 0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    #1;
    check_eq("post_rst_s_ready", s_ready, 1);
    check_eq("post_rst_m_valid", m_valid, 0);
    clear_model();
    $display("reset applied, model cleared");
  endtask

  task automatic run_cycle(input logic sv, input logic mr);
    int         k;
    logic [5:0] src;
    @(negedge clk);
    s_valid = sv;
    s_data  = WIDTH'(base + wr_idx);
    m_ready = mr;
    #1;
    cyc++;

    check_eq("w_r_exclusive", mem_w_en & mem_r_en, 0);
    if (chk_ready) begin
      check_eq("s_ready_after_done", s_ready, 1);
      chk_ready = 1'b0;
    end
    if (wr_idx == 64) check_eq("s_ready_drain", s_ready, 0);
    else check_eq("m_valid_fill", m_valid, 0);
    check_eq("w_en", mem_w_en, sv && (wr_idx < 64));

    if (sv && wr_idx < 64) begin
      check_eq("w_addr", mem_w_addr, wr_idx);
      check_eq("w_data", mem_d_in, s_data);
      blk_vals[wr_idx] = s_data;
      wr_idx++;
      if (wr_idx == 64) begin
        w64_cyc    = cyc;
        first_seen = 1'b0;
      end
    end

    if (prev_stall) begin
      check_eq("stall_valid", m_valid, 1);
      check_eq("stall_data", m_data, prev_data);
    end
    if (m_valid && wr_idx == 64 && !first_seen) begin
      check_eq("first_latency", cyc - w64_cyc, 2);
      first_seen = 1'b1;
    end
    check_eq("m_last", m_last, m_valid && (out_idx == 63));
    check_eq("blk_done", blk_done, m_valid && mr && (out_idx == 63));

    if (m_valid && mr) begin
      k   = out_idx;
      src = 6'((k % 8) * 8 + (k / 8));
      check_eq("m_data", m_data, blk_vals[src]);
      out_idx++;
    end
    prev_stall = m_valid && !mr;
    prev_data  = m_data;

    if (out_idx == 64) begin
      blocks_done++;
      $display("block %0d drained (base %0d) at cycle %0d", blocks_done, base, cyc);
      wr_idx     = 0;
      out_idx    = 0;
      base       = base + 64;
      chk_ready  = 1'b1;
      prev_stall = 1'b0;
    end
  endtask

  // sv_mode: 0 = always valid, 1 = valid every other cycle; mr_mode: 0 = always ready, 1 = ~30% stalls.
  task automatic run_blocks(input int n, input int sv_mode, input int mr_mode, input int budget);
    int  target;
    int  i;
    logic sv;
    logic mr;
    target = blocks_done + n;
    i = 0;
    while (blocks_done < target && i < budget) begin
      sv = (sv_mode == 0) ? 1'b1 : logic'(cyc[0]);
      mr = (mr_mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 30);
      run_cycle(sv, mr);
      i++;
    end
    check_eq("blocks_completed", blocks_done, target);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;

    do_reset();

    // Identity block 0..63 with no backpressure.
    base = 0;
    run_blocks(1, 0, 0, 400);

    // Upstream valid toggling every cycle.
    base = 1000;
    run_blocks(1, 1, 0, 600);

    // Downstream stalls about 30% of the time.
    base = 2000;
    run_blocks(1, 0, 1, 1000);

    // Partial block discarded by reset, then a fresh block.
    base = 3000;
    for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b1);
    check_eq("partial_writes", wr_idx, 20);
    do_reset();
    base = 4000;
    run_blocks(1, 0, 0, 400);

    // Two blocks back to back.
    base = 5000;
    run_blocks(2, 0, 0, 800);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/idct_transpose_ctrl.md
IDCT_TRANSPOSE_CTRL -- requirements
Module: idct_transpose_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the coefficient width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port s_valid, input, 1 bit: upstream row-pass coefficient valid.
REQ-005 The block SHALL have port s_ready, output, 1 bit: the block accepts an upstream coefficient.
REQ-006 The block SHALL have port s_data, input, WIDTH bits: upstream coefficient, row-major order.
REQ-007 The block SHALL have port mem_w_en, output, 1 bit: write enable to the 64-entry block memory.
REQ-008 The block SHALL have port mem_w_addr, output, 6 bits: memory write address.
REQ-009 The block SHALL have port mem_d_in, output, WIDTH bits: memory write data.
REQ-010 The block SHALL have port mem_r_en, output, 1 bit: memory read enable.
REQ-011 The block SHALL have port mem_r_addr, output, 6 bits: memory read address.
REQ-012 The block SHALL have port mem_d_out, input, WIDTH bits: memory read data, registered, 1-cycle latency, held while mem_r_en is low.
REQ-013 The block SHALL have port m_valid, output, 1 bit: column-order coefficient valid to the column pass.
REQ-014 The block SHALL have port m_ready, input, 1 bit: column pass accepts.
REQ-015 The block SHALL have port m_data, output, WIDTH bits: transposed coefficient.
REQ-016 The block SHALL have port m_last, output, 1 bit: m_data is the 64th coefficient of the block.
REQ-017 The block SHALL have port blk_done, output, 1 bit: one-cycle pulse when the last output beat is accepted.

Function
REQ-018 The FSM SHALL have two states, FILL and DRAIN, and SHALL reset to FILL.
REQ-019 In FILL, s_ready SHALL be 1; in DRAIN, s_ready SHALL be 0.
REQ-020 Each FILL-state s_valid&s_ready beat SHALL assert mem_w_en that same cycle, with mem_w_addr=wr_cnt and mem_d_in=s_data; wr_cnt then increments.
REQ-021 The beat with wr_cnt=63 SHALL wrap wr_cnt to 0 and move the FSM to DRAIN on the next cycle.
REQ-022 In DRAIN, mem_r_en SHALL assert when rd_cnt<64 issues remain and (!m_valid || m_ready).
REQ-023 mem_r_addr SHALL equal {rd_cnt[2:0], rd_cnt[5:3]}, giving column-major order; rd_cnt increments on each issue.
REQ-024 m_valid SHALL be set the cycle after an issue, and SHALL be cleared when m_ready is high and no issue occurred in the previous cycle.
REQ-025 m_data SHALL be driven directly from mem_d_out; the output SHALL stay stable while m_valid=1 and m_ready=0.
REQ-026 m_last SHALL be 1 exactly while m_valid=1 and the presented beat corresponds to rd_cnt issue 63.
REQ-027 On the accepted m_last beat, blk_done SHALL pulse, rd_cnt SHALL clear, and the FSM SHALL return to FILL on the next cycle.
REQ-028 Under zero backpressure, throughput SHALL be 1 beat/cycle; first m_valid SHALL occur 2 cycles after the 64th write.
REQ-029 mem_w_en and mem_r_en SHALL never be asserted in the same cycle.

Reset
REQ-030 While rst_n=0 at a clock edge: FSM=FILL, wr_cnt=0, rd_cnt=0, m_valid=0, m_last=0, blk_done=0, mem_w_en=0, mem_r_en=0.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial block; no stale m_valid SHALL appear after reset.

Structure
REQ-032 The shared IDCT package SHALL hold the state enum (FILL, DRAIN), BLK_SIZE=64 and DIM=8.
REQ-033 The block SHALL be a single module with no sub-modules; the 64-entry memory SHALL be instantiated by the parent.

Verification
REQ-034 Write 0..63 with m_ready=1 -> outputs 0,8,16,...,56,1,9,...,63, m_last on value 63, blk_done one cycle.
REQ-035 Write 64 beats with s_valid toggling 50% -> exactly 64 writes, addresses 0..63, then s_ready=0.
REQ-036 DRAIN with m_ready random 30% -> 64 accepted beats in transposed order, none duplicated or dropped, m_data stable while stalled.
REQ-037 rst_n=0 after 20 writes, then a fresh block of 64 writes -> only the fresh block is output, correct order.
REQ-038 Two back-to-back blocks -> s_ready returns to 1 the cycle after the first blk_done, and the second block is transposed correctly.
